mem_wb: RTL and testbench
=========================

# mem_wb

MEM/WB pipeline register and writeback driver for the THCOMIPS32e core. It captures the MEM stage results and drives the register file write port (we/waddr/wdata), HI/LO, LLbit and CP0 write ports from the WB stage. It applies the per-stage stall vector, pipeline flush and the $0 write-suppression rule. It also keeps a 32-bit count of retired instructions for the CP0/debug path.

## Interface
Parameters:
- DATA_W, 32, data width of GPR/HI/LO/CP0 values
- ADDR_W, 5, GPR and CP0 register address width

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- stall  in  6  per-stage stall vector; bit 4 = MEM stalled, bit 5 = WB stalled
- flush  in  1  synchronous pipeline flush (exception/eret)
- mem_valid  in  1  MEM holds a real instruction (not a bubble)
- mem_wreg  in  1  instruction writes a GPR
- mem_wd  in  ADDR_W  destination GPR
- mem_wdata  in  DATA_W  GPR write value
- mem_whilo  in  1  instruction writes HI/LO
- mem_hi, mem_lo  in  DATA_W  HI/LO write values
- mem_llbit_we, mem_llbit_value  in  1 each  LLbit write enable/value
- mem_cp0_we  in  1  CP0 write enable
- mem_cp0_addr  in  ADDR_W  CP0 register address
- mem_cp0_data  in  DATA_W  CP0 write value
- we  out  1  register file write enable
- waddr  out  ADDR_W  register file write address
- wdata  out  DATA_W  register file write data
- wb_whilo, wb_hi, wb_lo  out  1/DATA_W/DATA_W  HI/LO write port
- wb_llbit_we, wb_llbit_value  out  1/1  LLbit write port
- wb_cp0_we, wb_cp0_addr, wb_cp0_data  out  1/ADDR_W/DATA_W  CP0 write port
- wb_valid  out  1  WB holds a real instruction
- retire_cnt  out  32  retired-instruction counter

## Operation
- All WB-side outputs are registers. Outputs have no combinational path from the mem_* inputs.
- Update per rising edge, priority highest first:
  1. rst low (async): every output is 0, including retire_cnt.
  2. flush=1: all WB outputs except retire_cnt are cleared (bubble).
  3. stall[4]=1 and stall[5]=0: bubble inserted. All WB outputs except retire_cnt are cleared.
  4. stall[4]=1 and stall[5]=1: all outputs hold.
  5. stall[4]=0: capture the mem_* inputs.
- stall[4]=0 with stall[5]=1 is illegal. stall[5] is ignored in that case and the block captures.
- $0 rule: on capture, we = mem_wreg & (mem_wd != 0). waddr and wdata are captured unchanged.
- Enable gating: on capture, every write enable (we, wb_whilo, wb_llbit_we, wb_cp0_we) is ANDed with mem_valid. A bubble never writes.
- retire_cnt increments by 1 on every edge where a capture occurs with mem_valid=1.
  - Wraps 0xFFFF_FFFF -> 0.
  - Unaffected by flush and bubble cycles; cleared only by rst.
- The register file write happens in the cycle the outputs are presented. The register file handles same-cycle read-after-write forwarding; this block does not.

## Timing
- Latency: mem_* sampled at edge N appears on outputs after edge N, for one cycle unless held.
- Throughput: one instruction per cycle when unstalled.
- flush and a stall asserted at the same edge: flush wins and outputs clear.
- Reset deasserting mid-stream: the first capture is on the first edge with rst high. Outputs are 0 until then.
- retire_cnt changes at the same edge as the corresponding wb_valid rises.

## Test plan
- Reset: assert rst=0 asynchronously mid-cycle with outputs non-zero -> all outputs including retire_cnt read 0 before the next edge.
- Capture: mem_valid=1, mem_wreg=1, mem_wd=5, mem_wdata=0xDEADBEEF -> next cycle we=1, waddr=5, wdata=0xDEADBEEF, wb_valid=1, retire_cnt=1.
- $0 suppression: mem_wreg=1, mem_wd=0, mem_wdata=0x1234 -> we=0, wb_valid=1, retire_cnt increments.
- Stall: capture HI/LO write (hi=0xA, lo=0xB), then stall=6'b110000 for 3 cycles -> outputs held 3 cycles with retire_cnt unchanged. Then stall=6'b010000 -> bubble: all enables 0, wb_valid=0.
- Flush priority: flush=1 together with stall=6'b110000 while WB holds a CP0 write -> next cycle wb_cp0_we=0, wb_valid=0, retire_cnt unchanged.
- Counter wrap: preload via 2^32-1 retirements, or force retire_cnt to 0xFFFFFFFF in simulation -> one more valid capture gives retire_cnt=0.

Source files
------------

// File: rtl/mem_wb.sv
// MEM/WB pipeline register and writeback driver.
// Captures MEM-stage results and presents them as registered write ports
// for the GPR file, HI/LO, LLbit and CP0. Applies flush, the MEM/WB stall
// pair, $0 write suppression and bubble enable gating, and counts retired
// instructions.
module mem_wb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        stall,
    input  logic              flush,
    input  logic              mem_valid,
    input  logic              mem_wreg,
    input  logic [ADDR_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_whilo,
    input  logic [DATA_W-1:0] mem_hi,
    input  logic [DATA_W-1:0] mem_lo,
    input  logic              mem_llbit_we,
    input  logic              mem_llbit_value,
    input  logic              mem_cp0_we,
    input  logic [ADDR_W-1:0] mem_cp0_addr,
    input  logic [DATA_W-1:0] mem_cp0_data,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata,
    output logic              wb_whilo,
    output logic [DATA_W-1:0] wb_hi,
    output logic [DATA_W-1:0] wb_lo,
    output logic              wb_llbit_we,
    output logic              wb_llbit_value,
    output logic              wb_cp0_we,
    output logic [ADDR_W-1:0] wb_cp0_addr,
    output logic [DATA_W-1:0] wb_cp0_data,
    output logic              wb_valid,
    output logic [31:0]       retire_cnt
);

    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              whilo_q, whilo_d;
    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;
    logic              llwe_q, llwe_d;
    logic              llval_q, llval_d;
    logic              cp0we_q, cp0we_d;
    logic [ADDR_W-1:0] cp0addr_q, cp0addr_d;
    logic [DATA_W-1:0] cp0data_q, cp0data_d;
    logic              valid_q, valid_d;
    logic [31:0]       cnt_q, cnt_d;

    logic bubble_s;
    logic capture_s;

    // Decode the edge action: flush and MEM-stall-without-WB-stall insert a
    // bubble; an unstalled MEM captures (stall[5] alone is ignored).
    always_comb begin
        bubble_s  = flush | (stall[4] & ~stall[5]);
        capture_s = ~flush & ~stall[4];
    end

    // Next-state for the WB registers: bubble, hold or capture.
    always_comb begin
        we_d      = we_q;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        whilo_d   = whilo_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        llwe_d    = llwe_q;
        llval_d   = llval_q;
        cp0we_d   = cp0we_q;
        cp0addr_d = cp0addr_q;
        cp0data_d = cp0data_q;
        valid_d   = valid_q;
        if (bubble_s) begin
            we_d      = 1'b0;
            waddr_d   = {ADDR_W{1'b0}};
            wdata_d   = {DATA_W{1'b0}};
            whilo_d   = 1'b0;
            hi_d      = {DATA_W{1'b0}};
            lo_d      = {DATA_W{1'b0}};
            llwe_d    = 1'b0;
            llval_d   = 1'b0;
            cp0we_d   = 1'b0;
            cp0addr_d = {ADDR_W{1'b0}};
            cp0data_d = {DATA_W{1'b0}};
            valid_d   = 1'b0;
        end else if (capture_s) begin
            // Writes to $0 are dropped; a bubble in MEM never writes.
            we_d      = mem_valid & mem_wreg & (mem_wd != {ADDR_W{1'b0}});
            waddr_d   = mem_wd;
            wdata_d   = mem_wdata;
            whilo_d   = mem_valid & mem_whilo;
            hi_d      = mem_hi;
            lo_d      = mem_lo;
            llwe_d    = mem_valid & mem_llbit_we;
            llval_d   = mem_llbit_value;
            cp0we_d   = mem_valid & mem_cp0_we;
            cp0addr_d = mem_cp0_addr;
            cp0data_d = mem_cp0_data;
            valid_d   = mem_valid;
        end else begin
            // Both MEM and WB stalled: hold everything (defaults above).
            valid_d   = valid_q;
        end
    end

    // Retired-instruction counter: bumps on each capture of a real
    // instruction, wraps naturally, untouched by flush or bubbles.
    always_comb begin
        if (capture_s && mem_valid) begin
            cnt_d = cnt_q + 32'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // WB state registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q      <= 1'b0;
            waddr_q   <= {ADDR_W{1'b0}};
            wdata_q   <= {DATA_W{1'b0}};
            whilo_q   <= 1'b0;
            hi_q      <= {DATA_W{1'b0}};
            lo_q      <= {DATA_W{1'b0}};
            llwe_q    <= 1'b0;
            llval_q   <= 1'b0;
            cp0we_q   <= 1'b0;
            cp0addr_q <= {ADDR_W{1'b0}};
            cp0data_q <= {DATA_W{1'b0}};
            valid_q   <= 1'b0;
        end else begin
            we_q      <= we_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            whilo_q   <= whilo_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            llwe_q    <= llwe_d;
            llval_q   <= llval_d;
            cp0we_q   <= cp0we_d;
            cp0addr_q <= cp0addr_d;
            cp0data_q <= cp0data_d;
            valid_q   <= valid_d;
        end
    end

    // Retire counter register, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= 32'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Outputs come straight from the registers.
    always_comb begin
        we             = we_q;
        waddr          = waddr_q;
        wdata          = wdata_q;
        wb_whilo       = whilo_q;
        wb_hi          = hi_q;
        wb_lo          = lo_q;
        wb_llbit_we    = llwe_q;
        wb_llbit_value = llval_q;
        wb_cp0_we      = cp0we_q;
        wb_cp0_addr    = cp0addr_q;
        wb_cp0_data    = cp0data_q;
        wb_valid       = valid_q;
        retire_cnt     = cnt_q;
    end

endmodule

// File: tb/tb_mem_wb.sv
// Table-driven bench for mem_wb: per-cycle input/expected records plus
// hand-written sequences for asynchronous reset and counter wrap.
module tb_mem_wb;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic        mem_valid, mem_wreg;
    logic [4:0]  mem_wd;
    logic [31:0] mem_wdata;
    logic        mem_whilo;
    logic [31:0] mem_hi, mem_lo;
    logic        mem_llbit_we, mem_llbit_value;
    logic        mem_cp0_we;
    logic [4:0]  mem_cp0_addr;
    logic [31:0] mem_cp0_data;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        wb_whilo;
    logic [31:0] wb_hi, wb_lo;
    logic        wb_llbit_we, wb_llbit_value;
    logic        wb_cp0_we;
    logic [4:0]  wb_cp0_addr;
    logic [31:0] wb_cp0_data;
    logic        wb_valid;
    logic [31:0] retire_cnt;

    mem_wb #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .mem_valid(mem_valid), .mem_wreg(mem_wreg), .mem_wd(mem_wd),
        .mem_wdata(mem_wdata), .mem_whilo(mem_whilo), .mem_hi(mem_hi),
        .mem_lo(mem_lo), .mem_llbit_we(mem_llbit_we),
        .mem_llbit_value(mem_llbit_value), .mem_cp0_we(mem_cp0_we),
        .mem_cp0_addr(mem_cp0_addr), .mem_cp0_data(mem_cp0_data),
        .we(we), .waddr(waddr), .wdata(wdata), .wb_whilo(wb_whilo),
        .wb_hi(wb_hi), .wb_lo(wb_lo), .wb_llbit_we(wb_llbit_we),
        .wb_llbit_value(wb_llbit_value), .wb_cp0_we(wb_cp0_we),
        .wb_cp0_addr(wb_cp0_addr), .wb_cp0_data(wb_cp0_data),
        .wb_valid(wb_valid), .retire_cnt(retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0]  stall;
        logic        flush;
        logic        valid;
        logic        wreg;
        logic [4:0]  wd;
        logic [31:0] wdata;
        logic        whilo;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        llwe;
        logic        llval;
        logic        cp0we;
        logic [4:0]  cp0addr;
        logic [31:0] cp0data;
    } in_t;

    typedef struct packed {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        whilo;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        llwe;
        logic        llval;
        logic        cp0we;
        logic [4:0]  cp0addr;
        logic [31:0] cp0data;
        logic        valid;
        logic [31:0] cnt;
    } exp_t;

    typedef struct packed {
        in_t  i;
        exp_t e;
    } vec_t;

    int checks;
    int failures;
    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input exp_t e);
        chk({tag, ".we"},       {31'd0, we},             {31'd0, e.we});
        chk({tag, ".waddr"},    {27'd0, waddr},          {27'd0, e.waddr});
        chk({tag, ".wdata"},    wdata,                   e.wdata);
        chk({tag, ".whilo"},    {31'd0, wb_whilo},       {31'd0, e.whilo});
        chk({tag, ".hi"},       wb_hi,                   e.hi);
        chk({tag, ".lo"},       wb_lo,                   e.lo);
        chk({tag, ".llwe"},     {31'd0, wb_llbit_we},    {31'd0, e.llwe});
        chk({tag, ".llval"},    {31'd0, wb_llbit_value}, {31'd0, e.llval});
        chk({tag, ".cp0we"},    {31'd0, wb_cp0_we},      {31'd0, e.cp0we});
        chk({tag, ".cp0addr"},  {27'd0, wb_cp0_addr},    {27'd0, e.cp0addr});
        chk({tag, ".cp0data"},  wb_cp0_data,             e.cp0data);
        chk({tag, ".valid"},    {31'd0, wb_valid},       {31'd0, e.valid});
        chk({tag, ".cnt"},      retire_cnt,              e.cnt);
    endtask

    task automatic drive(input in_t i);
        stall           = i.stall;
        flush           = i.flush;
        mem_valid       = i.valid;
        mem_wreg        = i.wreg;
        mem_wd          = i.wd;
        mem_wdata       = i.wdata;
        mem_whilo       = i.whilo;
        mem_hi          = i.hi;
        mem_lo          = i.lo;
        mem_llbit_we    = i.llwe;
        mem_llbit_value = i.llval;
        mem_cp0_we      = i.cp0we;
        mem_cp0_addr    = i.cp0addr;
        mem_cp0_data    = i.cp0data;
    endtask

    // Build the cycle-by-cycle vector table with hand-computed expectations.
    task automatic build_table();
        vec_t v;
        exp_t held;
        // 0: plain GPR write to r5
        v = '0; v.i.valid = 1'b1; v.i.wreg = 1'b1; v.i.wd = 5'd5; v.i.wdata = 32'hDEADBEEF;
        v.e.we = 1'b1; v.e.waddr = 5'd5; v.e.wdata = 32'hDEADBEEF; v.e.valid = 1'b1; v.e.cnt = 32'd1;
        vecs.push_back(v);
        // 1: write to $0 suppressed, still retires
        v = '0; v.i.valid = 1'b1; v.i.wreg = 1'b1; v.i.wd = 5'd0; v.i.wdata = 32'h00001234;
        v.e.we = 1'b0; v.e.waddr = 5'd0; v.e.wdata = 32'h00001234; v.e.valid = 1'b1; v.e.cnt = 32'd2;
        vecs.push_back(v);
        // 2: HI/LO write
        v = '0; v.i.valid = 1'b1; v.i.whilo = 1'b1; v.i.hi = 32'hA; v.i.lo = 32'hB;
        v.i.wd = 5'd3; v.i.wdata = 32'd7;
        v.e.waddr = 5'd3; v.e.wdata = 32'd7; v.e.whilo = 1'b1; v.e.hi = 32'hA; v.e.lo = 32'hB;
        v.e.valid = 1'b1; v.e.cnt = 32'd3;
        held = v.e;
        vecs.push_back(v);
        // 3..5: MEM+WB stalled with changing inputs -> hold
        for (int k = 0; k < 3; k++) begin
            v = '0; v.i.stall = 6'b110000; v.i.valid = 1'b1; v.i.wreg = 1'b1;
            v.i.wd = 5'd9 + 5'(k); v.i.wdata = 32'h5555_0000 + 32'(k); v.i.cp0we = 1'b1;
            v.e = held;
            vecs.push_back(v);
        end
        // 6: MEM stalled, WB running -> bubble
        v = '0; v.i.stall = 6'b010000; v.i.valid = 1'b1; v.i.wreg = 1'b1; v.i.wd = 5'd4;
        v.e.cnt = 32'd3;
        vecs.push_back(v);
        // 7: invalid instruction in MEM: enables gated, data captured
        v = '0; v.i.valid = 1'b0; v.i.wreg = 1'b1; v.i.wd = 5'd7; v.i.wdata = 32'h55;
        v.i.whilo = 1'b1; v.i.hi = 32'd1; v.i.lo = 32'd2; v.i.llwe = 1'b1; v.i.llval = 1'b1;
        v.i.cp0we = 1'b1; v.i.cp0addr = 5'd12; v.i.cp0data = 32'h99;
        v.e.waddr = 5'd7; v.e.wdata = 32'h55; v.e.hi = 32'd1; v.e.lo = 32'd2; v.e.llval = 1'b1;
        v.e.cp0addr = 5'd12; v.e.cp0data = 32'h99; v.e.cnt = 32'd3;
        vecs.push_back(v);
        // 8: CP0 + LLbit write
        v = '0; v.i.valid = 1'b1; v.i.cp0we = 1'b1; v.i.cp0addr = 5'd12; v.i.cp0data = 32'h10;
        v.i.llwe = 1'b1;
        v.e.cp0we = 1'b1; v.e.cp0addr = 5'd12; v.e.cp0data = 32'h10; v.e.llwe = 1'b1;
        v.e.valid = 1'b1; v.e.cnt = 32'd4;
        vecs.push_back(v);
        // 9: flush together with full stall -> flush wins
        v = '0; v.i.stall = 6'b110000; v.i.flush = 1'b1; v.i.valid = 1'b1; v.i.wreg = 1'b1;
        v.i.wd = 5'd2;
        v.e.cnt = 32'd4;
        vecs.push_back(v);
        // 10: illegal stall (WB only) -> treated as capture
        v = '0; v.i.stall = 6'b100000; v.i.valid = 1'b1; v.i.wreg = 1'b1; v.i.wd = 5'd31;
        v.i.wdata = 32'hFFFFFFFF;
        v.e.we = 1'b1; v.e.waddr = 5'd31; v.e.wdata = 32'hFFFFFFFF; v.e.valid = 1'b1; v.e.cnt = 32'd5;
        vecs.push_back(v);
        // 11: flush alone with valid MEM -> bubble, no retire
        v = '0; v.i.flush = 1'b1; v.i.valid = 1'b1; v.i.wreg = 1'b1; v.i.wd = 5'd8;
        v.e.cnt = 32'd5;
        vecs.push_back(v);
        // 12: write r1 to leave outputs non-zero
        v = '0; v.i.valid = 1'b1; v.i.wreg = 1'b1; v.i.wd = 5'd1; v.i.wdata = 32'd1;
        v.e.we = 1'b1; v.e.waddr = 5'd1; v.e.wdata = 32'd1; v.e.valid = 1'b1; v.e.cnt = 32'd6;
        vecs.push_back(v);
    endtask

    in_t  idle_i;
    exp_t zero_e;
    exp_t e_tmp;

    initial begin
        checks   = 0;
        failures = 0;
        idle_i   = '0;
        zero_e   = '0;
        drive(idle_i);
        rst = 1'b0;
        build_table();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", zero_e);
        @(negedge clk);
        rst = 1'b1;

        for (int n = 0; n < vecs.size(); n++) begin
            @(negedge clk);
            drive(vecs[n].i);
            @(posedge clk);
            #1;
            check_all($sformatf("vec%0d", n), vecs[n].e);
        end

        // Asynchronous reset mid-cycle with non-zero outputs.
        @(negedge clk);
        drive(idle_i);
        #2;
        rst = 1'b0;
        #1;
        check_all("async_rst", zero_e);
        // Capture attempted while held in reset: outputs stay zero.
        e_tmp = '0; e_tmp.valid = 1'b1;
        mem_valid = 1'b1; mem_wreg = 1'b1; mem_wd = 5'd6; mem_wdata = 32'h66;
        @(posedge clk);
        #1;
        check_all("in_rst", zero_e);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        e_tmp = '0; e_tmp.we = 1'b1; e_tmp.waddr = 5'd6; e_tmp.wdata = 32'h66;
        e_tmp.valid = 1'b1; e_tmp.cnt = 32'd1;
        check_all("first_after_rst", e_tmp);

        // Counter wrap: preload all-ones, one valid retirement -> 0.
        @(negedge clk);
        force dut.cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.cnt_q;
        #1;
        chk("preload", retire_cnt, 32'hFFFF_FFFF);
        mem_valid = 1'b1; mem_wreg = 1'b0; mem_wd = 5'd2; mem_wdata = 32'h22;
        @(posedge clk);
        #1;
        e_tmp = '0; e_tmp.waddr = 5'd2; e_tmp.wdata = 32'h22; e_tmp.valid = 1'b1; e_tmp.cnt = 32'd0;
        check_all("wrap", e_tmp);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
